axis_packet_tx: RTL and testbench
=================================

// Module: axis_packet_tx
// PURPOSE
//  Upstream framer for the cell link: turns a parallel packet request (index + data words) into an AXI-Stream packet.
//  Each packet is one header word followed by NUM_DATA_WORDS data words, with TLAST on the final data word.
//  The output drives the Aurora TX AXIS port; the far-end receive checker validates the header magic and the packet size.
// PARAMETERS
//  MAGIC_WIDTH      16   header magic field width
//  MAGIC_START_BIT  16   LSB of magic in header; INDEX_START_BIT+INDEX_WIDTH-1 < MAGIC_START_BIT (elaboration error otherwise)
//  INDEX_WIDTH      5    cell index field width
//  INDEX_START_BIT  10   LSB of index in header
//  NUM_DATA_WORDS   1    32-bit data words per packet; must be >=1 (elaboration error otherwise)
// PORTS
//  auroraClk      in   1                  sole clock
//  auroraResetN   in   1                  asynchronous, active-low reset
//  newCycleStrobe in   1                  start of a new exchange cycle; flushes the pending request
//  headerMagic    in   MAGIC_WIDTH        magic inserted in every header (quasi-static)
//  sendStrobe     in   1                  1-cycle request to send a packet
//  sendIndex      in   INDEX_WIDTH        index captured with sendStrobe
//  sendData       in   32*NUM_DATA_WORDS  data captured with sendStrobe; word j = bits [32j+31:32j], sent j=0 first
//  TVALID         out  1                  AXIS valid
//  TREADY         in   1                  AXIS ready
//  TLAST          out  1                  AXIS last
//  TDATA          out  32                 AXIS data
//  busy           out  1                  a packet is in flight or a request is pending
//  sentCount      out  16                 packets completed, wraps 0xFFFF->0
//  dropCount      out  16                 requests dropped, saturates at 0xFFFF
// BEHAVIOUR
//  Reset (async assert, sync release): TVALID=0, TLAST=0, TDATA=0, busy=0, counts=0, state=S_IDLE, pending empty.
//  Beat transfer = TVALID&&TREADY at a rising edge. Once TVALID=1, TVALID/TDATA/TLAST hold until the beat transfers; no other signal (including newCycleStrobe) drops or alters them.
//  FSM:
//   S_IDLE:   request available (new strobe or pending) -> load it; drive header; TVALID=1 -> S_HEADER.
//   S_HEADER: on beat -> TDATA=word0; TLAST=(NUM_DATA_WORDS==1) -> S_DATA, wordCnt=0.
//   S_DATA:   on beat with TLAST -> sentCount++. If pending: load header next cycle, no idle gap (-> S_HEADER). Else TVALID=0 -> S_IDLE.
//             on beat without TLAST -> wordCnt++; TDATA=word[wordCnt+1]; TLAST when wordCnt+1==NUM_DATA_WORDS-1.
//  Header word: magic at [MAGIC_START_BIT+:MAGIC_WIDTH], index at [INDEX_START_BIT+:INDEX_WIDTH]; all other bits 0.
//  Latency: sendStrobe in IDLE -> TVALID high with header on the next cycle (1 clk).
//  Request buffer: 1 entry.
//   sendStrobe while in flight: stored in pending if empty; if pending is full -> request dropped, dropCount++, pending unchanged.
//   sendStrobe in the same cycle as the final beat: stored in pending and sent back-to-back.
//   sendStrobe in the same cycle as newCycleStrobe: the flush happens first, then the new request is accepted.
//  newCycleStrobe: clears pending only; an in-flight packet completes normally.
//  busy = (state!=S_IDLE) || pending valid.
// CONFIGURATION
//  AXIS_PACKET_TX_FAULT_INJECT_EN defined: adds inputs injectBadMagic and injectShort, sampled with sendStrobe and stored per request.
//   injectBadMagic: header magic = ~headerMagic.
//   injectShort: TLAST on the header beat; no data words follow; counts as sent.
//  Undefined: these ports and this logic are absent; headers are always correct and packets always full length.
// STRUCTURE
//  Package cell_comm_pkg: S_IDLE/S_HEADER/S_DATA encodings; MAGIC/INDEX field defaults; function f_build_header(magic,index).
//  Sub-module axis_packet_tx_req_buf: 1-deep pending register holding index, data and (if enabled) inject flags.
//   Interfaces: push/pop/flush/full, drop pulse.
//  Word mux uses wordCnt of width $clog2(NUM_DATA_WORDS+1).
// TESTING
//  T1: NUM_DATA_WORDS=1, magic=0xA5A5, index=3, TREADY=1.
//   -> header 0xA5A50C00, then data with TLAST; sentCount=1; busy drops 1 clk after the last beat.
//  T2: NUM_DATA_WORDS=4, TREADY random 50%.
//   -> 5 beats, in order; TDATA/TLAST stable while stalled; TLAST only on beat 5.
//  T3: 3 strobes on consecutive cycles during a packet.
//   -> 2nd strobe pending, 3rd dropped (dropCount=1); pending packet starts the cycle after the final beat.
//  T4: newCycleStrobe while pending is full, mid-packet.
//   -> current packet completes; pending discarded; sentCount+1 only; busy=0 after.
//  T5: auroraResetN low mid-packet with TVALID=1.
//   -> TVALID=0 immediately (async); after release, a new request sends a clean header.
//  T6 (FAULT_INJECT_EN): injectShort=1, then injectBadMagic=1.
//   -> 1-beat packet with TLAST; then a header with magic 0x5A5A; the checker reports BAD_SIZE and BAD_HEADER.

Source files
------------

// File: rtl/cell_comm_pkg.sv
// cell_comm_pkg: shared FSM encodings, header field defaults and header builder for the cell link.
package cell_comm_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HEADER = 2'd1, S_DATA = 2'd2} state_e;
  localparam int MAGIC_WIDTH_DEF     = 16;
  localparam int MAGIC_START_BIT_DEF = 16;
  localparam int INDEX_WIDTH_DEF     = 5;
  localparam int INDEX_START_BIT_DEF = 10;
  function automatic logic [31:0] f_build_header(input logic [31:0] magic, input logic [31:0] index,
                                                 input int magic_lsb = MAGIC_START_BIT_DEF,
                                                 input int index_lsb = INDEX_START_BIT_DEF);
    return (magic << magic_lsb) | (index << index_lsb);
  endfunction
endpackage

// File: rtl/axis_packet_tx_req_buf.sv
// axis_packet_tx_req_buf: 1-deep pending request register; flush and pop free the slot before a push is judged.
module axis_packet_tx_req_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic [W-1:0] data_o,
  output logic         drop_o
);
  logic         full_q, full_d, keep;
  logic [W-1:0] data_q;
  assign keep   = full_q && !flush_i && !pop_i;
  assign drop_o = push_i && keep;
  assign full_d = keep || push_i;
  assign full_o = full_q;
  assign data_o = data_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      if (push_i && !keep) data_q <= data_i;
    end
  end
endmodule

// File: rtl/axis_packet_tx.sv
// axis_packet_tx: frames packet requests (header + data words) onto an AXI-Stream TX port.
// Optional AXIS_PACKET_TX_FAULT_INJECT_EN adds per-request bad-magic and short-packet injection.
module axis_packet_tx
  import cell_comm_pkg::*;
#(
  parameter int MAGIC_WIDTH     = MAGIC_WIDTH_DEF,
  parameter int MAGIC_START_BIT = MAGIC_START_BIT_DEF,
  parameter int INDEX_WIDTH     = INDEX_WIDTH_DEF,
  parameter int INDEX_START_BIT = INDEX_START_BIT_DEF,
  parameter int NUM_DATA_WORDS  = 1
) (
  input  logic                         auroraClk,
  input  logic                         auroraResetN,
  input  logic                         newCycleStrobe,
  input  logic [MAGIC_WIDTH-1:0]       headerMagic,
  input  logic                         sendStrobe,
  input  logic [INDEX_WIDTH-1:0]       sendIndex,
  input  logic [32*NUM_DATA_WORDS-1:0] sendData,
`ifdef AXIS_PACKET_TX_FAULT_INJECT_EN
  input  logic                         injectBadMagic,
  input  logic                         injectShort,
`endif
  output logic                         TVALID,
  input  logic                         TREADY,
  output logic                         TLAST,
  output logic [31:0]                  TDATA,
  output logic                         busy,
  output logic [15:0]                  sentCount,
  output logic [15:0]                  dropCount
);
  localparam int WC = $clog2(NUM_DATA_WORDS + 1);
  localparam int DW = 32 * NUM_DATA_WORDS;
`ifdef AXIS_PACKET_TX_FAULT_INJECT_EN
  localparam int PW = DW + INDEX_WIDTH + 2;
`else
  localparam int PW = DW + INDEX_WIDTH;
`endif
  if (INDEX_START_BIT + INDEX_WIDTH - 1 >= MAGIC_START_BIT) begin : g_bad_fields
    $error("axis_packet_tx: index field overlaps magic field");
  end
  if (NUM_DATA_WORDS < 1) begin : g_bad_words
    $error("axis_packet_tx: NUM_DATA_WORDS must be >= 1");
  end
  state_e            state_q, state_d;
  logic              tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [31:0]       tdata_q, tdata_d;
  logic [DW-1:0]     words_q, words_d;
  logic [WC-1:0]     wc_q, wc_d, wc_nx;
  logic [15:0]       sent_q, sent_d, drop_q, drop_d;
  logic [PW-1:0]     req_in, buf_data, ld;
  logic              buf_full, drop, beat, done, pend_v, can_load, pop, push, load, ld_bad, ld_short;
`ifdef AXIS_PACKET_TX_FAULT_INJECT_EN
  assign req_in   = {injectBadMagic, injectShort, sendIndex, sendData};
  assign ld_bad   = ld[PW-1];
  assign ld_short = ld[PW-2];
`else
  assign req_in   = {sendIndex, sendData};
  assign ld_bad   = 1'b0;
  assign ld_short = 1'b0;
`endif
  assign beat     = tvalid_q && TREADY;
  assign done     = beat && tlast_q;
  assign pend_v   = buf_full && !newCycleStrobe;
  assign can_load = (state_q == S_IDLE) || done;
  assign pop      = can_load && pend_v;
  assign load     = can_load && (pend_v || sendStrobe);
  // A strobe that cannot go straight onto the wire is offered to the pending slot.
  assign push     = sendStrobe && !(can_load && !pend_v);
  assign ld       = pop ? buf_data : req_in;
  assign wc_nx    = wc_q + 1'b1;
  axis_packet_tx_req_buf #(.W(PW)) u_req_buf (
    .clk(auroraClk), .rst_n(auroraResetN), .push_i(push), .pop_i(pop), .flush_i(newCycleStrobe),
    .data_i(req_in), .full_o(buf_full), .data_o(buf_data), .drop_o(drop)
  );
  always_comb begin
    state_d  = state_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    words_d  = words_q;
    wc_d     = wc_q;
    sent_d   = sent_q + 16'(done);
    drop_d   = drop_q + 16'(drop && drop_q != 16'hFFFF);
    if (load) begin
      state_d  = S_HEADER;
      tvalid_d = 1'b1;
      tlast_d  = ld_short;
      words_d  = ld[DW-1:0];
      tdata_d  = f_build_header(32'(ld_bad ? ~headerMagic : headerMagic), 32'(ld[DW+:INDEX_WIDTH]),
                                MAGIC_START_BIT, INDEX_START_BIT);
    end else if (done) begin
      state_d  = S_IDLE;
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end else if (beat && state_q == S_HEADER) begin
      state_d = S_DATA;
      tdata_d = words_q[31:0];
      tlast_d = (NUM_DATA_WORDS == 1);
      wc_d    = '0;
    end else if (beat) begin
      wc_d    = wc_nx;
      tdata_d = 32'(words_q >> {wc_nx, 5'd0});
      tlast_d = (wc_nx == WC'(NUM_DATA_WORDS - 1));
    end
  end
  always_ff @(posedge auroraClk or negedge auroraResetN) begin
    if (!auroraResetN) begin
      state_q  <= S_IDLE;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      words_q  <= '0;
      wc_q     <= '0;
      sent_q   <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      words_q  <= words_d;
      wc_q     <= wc_d;
      sent_q   <= sent_d;
      drop_q   <= drop_d;
    end
  end
  assign TVALID    = tvalid_q;
  assign TLAST     = tlast_q;
  assign TDATA     = tdata_q;
  assign busy      = (state_q != S_IDLE) || buf_full;
  assign sentCount = sent_q;
  assign dropCount = drop_q;
endmodule

// File: tb/tb_axis_packet_tx.sv
// tb_axis_packet_tx: randomized bench for axis_packet_tx at 1 and 4 data words, against a packet-queue model.
module tb_axis_packet_tx;
`ifdef AXIS_PACKET_TX_FAULT_INJECT_EN
  localparam bit FI = 1'b1;
`else
  localparam bit FI = 1'b0;
`endif
  logic         clk = 1'b0, rst_n = 1'b0, new_cycle = 1'b0, strobe = 1'b0, bad = 1'b0, short_f = 1'b0;
  logic [15:0]  magic = 16'hA5A5;
  logic [4:0]   idx = '0;
  logic [127:0] data = '0;
  logic [1:0]   tready = '0, tvalid, tlast, busy;
  logic [31:0]  tdata [2];
  logic [15:0]  sent [2], drop [2];
  int           tests = 0, fails = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int N = g ? 4 : 1;
    axis_packet_tx #(.NUM_DATA_WORDS(N)) dut (
      .auroraClk(clk), .auroraResetN(rst_n), .newCycleStrobe(new_cycle), .headerMagic(magic),
      .sendStrobe(strobe), .sendIndex(idx), .sendData(data[32*N-1:0]),
`ifdef AXIS_PACKET_TX_FAULT_INJECT_EN
      .injectBadMagic(bad), .injectShort(short_f),
`endif
      .TVALID(tvalid[g]), .TREADY(tready[g]), .TLAST(tlast[g]), .TDATA(tdata[g]),
      .busy(busy[g]), .sentCount(sent[g]), .dropCount(drop[g])
    );
    // Each queue entry is {last, word}; cur is the packet on the wire, pend the buffered one.
    logic [32:0] cur [$], pend [$];
    bit          pv;
    int          exp_sent, exp_drop;
    always @(negedge clk) begin : mon
      logic [32:0] pkt [$];
      logic [31:0] hdr;
      bit          sh;
      pkt.delete();
      if (!rst_n) begin
        cur.delete();
        pv = 0; exp_sent = 0; exp_drop = 0;
        check("rst_valid", 32'(tvalid[g]), 0);
        check("rst_last", 32'(tlast[g]), 0);
        check("rst_data", tdata[g], 0);
        check("rst_busy", 32'(busy[g]), 0);
        check("rst_cnt", {sent[g], drop[g]}, 0);
      end else begin
        check("valid", 32'(tvalid[g]), 32'(cur.size() != 0));
        if (cur.size() != 0) begin
          check("data", tdata[g], cur[0][31:0]);
          check("last", 32'(tlast[g]), 32'(cur[0][32]));
        end
        check("busy", 32'(busy[g]), 32'(cur.size() != 0 || pv));
        check("sent", 32'(sent[g]), exp_sent);
        check("drop", 32'(drop[g]), exp_drop);
        sh  = FI && short_f;
        hdr = (32'((FI && bad) ? ~magic : magic) << 16) | (32'(idx) << 10);
        pkt.push_back({sh, hdr});
        if (!sh) for (int j = 0; j < N; j++) pkt.push_back({j == N - 1, data[32*j+:32]});
        if (cur.size() != 0 && tready[g]) begin
          if (cur[0][32]) exp_sent = (exp_sent + 1) % 65536;
          void'(cur.pop_front());
        end
        if (new_cycle) pv = 0;
        if (cur.size() == 0) begin
          if (pv) begin
            cur = pend; pv = 0;
            if (strobe) begin pend = pkt; pv = 1; end
          end else if (strobe) cur = pkt;
        end else if (strobe) begin
          if (pv) exp_drop = exp_drop + (exp_drop < 65535 ? 1 : 0);
          else begin pend = pkt; pv = 1; end
        end
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic wait_idle;
    for (int k = 0; k < 300 && busy != 2'b00; k++) tick();
    check("idle_timeout", 32'(busy), 0);
  endtask
  task automatic send(input logic [4:0] i);
    idx = i;
    data = {$urandom, $urandom, $urandom, $urandom};
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
  endtask
  initial begin
    logic [15:0] d0, s0, s1;
    repeat (3) tick();
    rst_n = 1'b1;
    tready = 2'b11;
    tick();
    send(5'd3);
    check("t1_valid", 32'(tvalid), 32'h3);
    check("t1_hdr", tdata[0], 32'hA5A50C00);
    tick();
    check("t1_lastbeat", 32'(tlast[0]), 1);
    tick();
    check("t1_busy_drop", 32'(busy[0]), 0);
    check("t1_sent", 32'(sent[0]), 1);
    wait_idle();
    tready = 2'b00;
    d0 = drop[1];
    send(5'd1);
    send(5'd2);
    send(5'd4);
    check("t3_drop", 32'(drop[1] - d0), 1);
    s0 = sent[0]; s1 = sent[1];
    new_cycle = 1'b1;
    tick();
    new_cycle = 1'b0;
    tready = 2'b11;
    wait_idle();
    check("t4_sent0", 32'(sent[0] - s0), 1);
    check("t4_sent1", 32'(sent[1] - s1), 1);
    for (int c = 0; c < 2000; c++) begin
      tready    = 2'($urandom);
      strobe    = ($urandom_range(0, 2) == 0);
      new_cycle = ($urandom_range(0, 19) == 0);
      idx       = 5'($urandom);
      data      = {$urandom, $urandom, $urandom, $urandom};
      bad       = FI && ($urandom_range(0, 3) == 0);
      short_f   = FI && ($urandom_range(0, 3) == 0);
      tick();
    end
    strobe = 1'b0; new_cycle = 1'b0; bad = 1'b0; short_f = 1'b0;
    tready = 2'b11;
    wait_idle();
    magic = 16'h1234;
    tready = 2'b00;
    send(5'd9);
    check("t5_pre", 32'(tvalid), 32'h3);
    rst_n = 1'b0;
    #1;
    check("t5_async", 32'(tvalid), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tready = 2'b11;
    tick();
    send(5'd7);
    check("t5_hdr0", tdata[0], 32'h12341C00);
    check("t5_hdr1", tdata[1], 32'h12341C00);
    wait_idle();
    check("t5_sent", 32'(sent[1]), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
